// File: rtl/adc_sum_sq_sched.sv
// rtl/adc_sum_sq_sched.sv - round-robin ADC sum-of-squares scheduler
//
// Purpose:
//   A single square-and-accumulate datapath is shared across N_CH ADC channels.
//   Channels are integrated in round-robin order. Each channel is integrated over
//   a window of 2^w samples, and the 32-bit result is latched into a per-channel
//   holding word. The holding words feed the software-readable registers.
//
// Ports:
//   user_clk     block clock
//   user_rst     asynchronous active-high reset
//   enable       run scheduler; low returns to IDLE and discards partial work
//   arm_on_sync  1: each sweep waits for sync_in; 0: free-run
//   sync_in      single-cycle sync pulse, only honoured in ARM
//   win_log2     window exponent, sampled on ACCUM entry, clamped to WIN_LOG2_MAX
//   adc_valid    qualifies adc_data
//   adc_data     packed signed samples, ch0 in the LSBs
//   sum_sq       held results, ch k at [32k+31:32k]
//   dump_valid   high for the single cycle a result is written
//   dump_ch      channel written on the dump_valid cycle
//   cur_ch       channel currently being integrated
//   busy         high in ACCUM/DRAIN/DUMP
//   sweep_cnt    completed full sweeps, wraps
module adc_sum_sq_sched #(
  parameter int N_CH         = 4,
  parameter int DATA_W       = 8,
  parameter int WIN_LOG2_MAX = 20
) (
  input  logic                   user_clk,
  input  logic                   user_rst,
  input  logic                   enable,
  input  logic                   arm_on_sync,
  input  logic                   sync_in,
  input  logic [4:0]             win_log2,
  input  logic                   adc_valid,
  input  logic [N_CH*DATA_W-1:0] adc_data,
  output logic [N_CH*32-1:0]     sum_sq,
  output logic                   dump_valid,
  output logic [3:0]             dump_ch,
  output logic [3:0]             cur_ch,
  output logic                   busy,
  output logic [15:0]            sweep_cnt
);

  localparam int         SQ_W    = 2 * DATA_W;
  localparam int         CNT_W   = WIN_LOG2_MAX + 1;
  localparam int         CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [4:0] WIN_MAX = 5'(WIN_LOG2_MAX);
  localparam logic [3:0] LAST_CH = 4'(N_CH - 1);
  localparam logic [32:0] ACC_SAT = 33'h0_FFFF_FFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_ACCUM,
    S_DRAIN,
    S_DUMP
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [4:0]       win_q;
  logic [CNT_W-1:0] cnt_q;
  logic [32:0]      acc_q;
  logic [SQ_W-1:0]  sq_q;
  logic             sq_vld_q;
  logic [3:0]       cur_ch_q;
  logic [3:0]       dump_ch_q;
  logic [15:0]      sweep_q;
  logic [31:0]      sum_sq_q [N_CH];

  logic signed [DATA_W-1:0] ch_sample [N_CH];
  logic [CH_W-1:0]          cur_idx;
  logic signed [DATA_W-1:0] cur_sample;
  logic signed [SQ_W-1:0]   s_ext;
  logic signed [SQ_W-1:0]   sq_next;
  logic [4:0]               win_clamp;
  logic [CNT_W-1:0]         win_target;
  logic                     cnt_full;
  logic                     take;
  logic                     enter_accum;
  logic [32:0]              acc_sum;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    assign ch_sample[k]      = adc_data[k*DATA_W +: DATA_W];
    assign sum_sq[k*32 +: 32] = sum_sq_q[k];
  end

  assign cur_idx    = cur_ch_q[CH_W-1:0];
  assign cur_sample = ch_sample[cur_idx];

  // Sign-extend before multiplying so the square is exact in SQ_W bits;
  // the result is non-negative and is stored as unsigned.
  assign s_ext   = SQ_W'(cur_sample);
  assign sq_next = s_ext * s_ext;

  assign win_clamp  = (win_log2 > WIN_MAX) ? WIN_MAX : win_log2;
  assign win_target = CNT_W'(1) << win_q;
  assign cnt_full   = (cnt_q == win_target);

  // A sample is only accepted while the window still has room; once the count
  // is full the FSM spends one more ACCUM cycle deciding to leave.
  assign take        = (state_q == S_ACCUM) && adc_valid && !cnt_full;
  assign enter_accum = (state_d == S_ACCUM) && (state_q != S_ACCUM);

  // Accumulator is 33 bits so the carry out of the 32-bit range is visible.
  assign acc_sum = acc_q + 33'(sq_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (enable) state_d = S_ARM;
      S_ARM:   if (!arm_on_sync || sync_in) state_d = S_ACCUM;
      S_ACCUM: if (cnt_full) state_d = S_DRAIN;
      S_DRAIN: state_d = S_DUMP;
      S_DUMP:  state_d = (cur_ch_q == LAST_CH) ? S_ARM : S_ACCUM;
      default: state_d = S_IDLE;
    endcase
    if (!enable) state_d = S_IDLE;
  end

  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      state_q   <= S_IDLE;
      win_q     <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      sq_q      <= '0;
      sq_vld_q  <= 1'b0;
      cur_ch_q  <= '0;
      dump_ch_q <= '0;
      sweep_q   <= '0;
      for (int k = 0; k < N_CH; k++) sum_sq_q[k] <= '0;
    end else begin
      state_q <= state_d;

      // Stage 1: square of the accepted sample. Dropping enable kills any
      // square still in flight so nothing leaks into the next window.
      sq_vld_q <= take && enable;
      if (take) sq_q <= sq_next;

      // Stage 2: accumulate. Entry to ACCUM or abort to IDLE restarts the window.
      if (enter_accum || state_d == S_IDLE) begin
        cnt_q <= '0;
        acc_q <= '0;
        if (enter_accum) win_q <= win_clamp;
      end else begin
        if (take) cnt_q <= cnt_q + CNT_W'(1);
        // Sticky saturation: once past 2^32-1 the sum stays at all-ones.
        if (sq_vld_q) acc_q <= acc_sum[32] ? ACC_SAT : acc_sum;
      end

      if (state_d == S_DUMP) dump_ch_q <= cur_ch_q;

      // The dump always completes, even when enable falls in this cycle.
      if (state_q == S_DUMP) begin
        sum_sq_q[cur_idx] <= acc_q[32] ? 32'hFFFF_FFFF : acc_q[31:0];
        if (cur_ch_q == LAST_CH) begin
          cur_ch_q <= '0;
          sweep_q  <= sweep_q + 16'd1;
        end else begin
          cur_ch_q <= cur_ch_q + 4'd1;
        end
      end

      if (state_d == S_IDLE) cur_ch_q <= '0;
    end
  end

  assign dump_valid = (state_q == S_DUMP);
  assign dump_ch    = dump_ch_q;
  assign cur_ch     = cur_ch_q;
  assign busy       = (state_q == S_ACCUM) || (state_q == S_DRAIN) || (state_q == S_DUMP);
  assign sweep_cnt  = sweep_q;

endmodule
